// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizing constants and depth helper shared by the register file
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ZERO_IDX = 31;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bits for pending writes, busy counter and per-port hazard lookup
import regfile_pkg::*;
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ = 2,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_idx,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_idx,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_idx,
  output logic [NUM_READ-1:0]            rd_busy,
  output logic [ADDR_WIDTH:0]            busy_count
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW = count_width(DEPTH);
  logic [DEPTH-1:0] busy;
  logic clr, inc, dec;
  // a reservation of the register being written supersedes the completing write
  always_comb begin
    clr = wr_en && !(rsv_en && rsv_idx == wr_idx);
    inc = rsv_en && !busy[rsv_idx];
    dec = clr && busy[wr_idx];
  end
  // busy bits and incrementally maintained count of set bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      busy_count <= '0;
    end else begin
      if (clr) busy[wr_idx] <= 1'b0;
      if (rsv_en) busy[rsv_idx] <= 1'b1;
      busy_count <= busy_count + CW'(inc) - CW'(dec);
    end
  end
  // a register completing this cycle is already safe to read when bypass forwards it
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_READ; p++)
      rd_busy[p] = busy[rd_idx[p*ADDR_WIDTH +: ADDR_WIDTH]] &&
                   !(BYPASS != 0 && clr && wr_idx == rd_idx[p*ADDR_WIDTH +: ADDR_WIDTH]);
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass, zero register and busy scoreboard
import regfile_pkg::*;
module regfile_mp #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ = 2,
  parameter int ZERO_EN = 1,
  parameter int ZERO_IDX = depth_of(ADDR_WIDTH) - 1,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           RegWrite,
  input  logic [ADDR_WIDTH-1:0]          WriteRegister,
  input  logic [DATA_WIDTH-1:0]          WriteData,
  input  logic                           Reserve,
  input  logic [ADDR_WIDTH-1:0]          ReserveRegister,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister,
  output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
  output logic [NUM_READ-1:0]            ReadBusy,
  output logic [ADDR_WIDTH:0]            BusyCount
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZI = ADDR_WIDTH'(ZERO_IDX);
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic wr_eff, rsv_eff;
  logic [ADDR_WIDTH-1:0] ri;
  // writes and reservations to the zero register are dropped; nothing is forwarded while in reset
  always_comb begin
    wr_eff = reset_n && RegWrite && !(ZERO_EN != 0 && WriteRegister == ZI);
    rsv_eff = reset_n && Reserve && !(ZERO_EN != 0 && ReserveRegister == ZI);
  end
  // register storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[WriteRegister] <= WriteData;
    end
  end
  // read muxing: zero register, then same-cycle forward, then stored value
  always_comb begin
    ReadData = '0;
    ri = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      ri = ReadRegister[p*ADDR_WIDTH +: ADDR_WIDTH];
      ReadData[p*DATA_WIDTH +: DATA_WIDTH] =
        (ZERO_EN != 0 && ri == ZI) ? '0 :
        (BYPASS != 0 && wr_eff && WriteRegister == ri) ? WriteData : regs[ri];
    end
  end
  regfile_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_READ(NUM_READ),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(wr_eff),
    .wr_idx(WriteRegister),
    .rsv_en(rsv_eff),
    .rsv_idx(ReserveRegister),
    .rd_idx(ReadRegister),
    .rd_busy(ReadBusy),
    .busy_count(BusyCount)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp with and without write bypass
module tb_regfile_mp;
  localparam logic [63:0] PAT = 64'h0000010204080001;
  logic clk = 1'b0;
  logic reset_n;
  logic reg_write;
  logic [4:0] write_register;
  logic [63:0] write_data;
  logic reserve;
  logic [4:0] reserve_register;
  logic [9:0] read_register;
  logic [127:0] rd_data, nb_data;
  logic [1:0] rd_busy, nb_busy;
  logic [5:0] busy_count, nb_count;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .reset_n(reset_n), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .Reserve(reserve), .ReserveRegister(reserve_register),
    .ReadRegister(read_register), .ReadData(rd_data), .ReadBusy(rd_busy), .BusyCount(busy_count)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .Reserve(reserve), .ReserveRegister(reserve_register),
    .ReadRegister(read_register), .ReadData(nb_data), .ReadBusy(nb_busy), .BusyCount(nb_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write = 1'b0;
    reserve = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    reg_write = 1'b0;
    write_register = '0;
    write_data = '0;
    reserve = 1'b0;
    reserve_register = '0;
    read_register = '0;
    #2;
    chk("reset_data", 64'(rd_data), 64'h0);
    chk("reset_busy", 64'(rd_busy), 64'h0);
    chk("reset_count", 64'(busy_count), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    // zero register ignores writes and reservations
    reg_write = 1'b1; write_register = 5'd31; write_data = 64'hA0;
    reserve = 1'b1; reserve_register = 5'd31;
    read_register = {5'd31, 5'd31};
    #1;
    chk("zero_bypass", rd_data[63:0], 64'h0);
    tick();
    idle();
    #1;
    chk("zero_data0", rd_data[63:0], 64'h0);
    chk("zero_data1", rd_data[127:64], 64'h0);
    chk("zero_busy", 64'(rd_busy), 64'h0);
    chk("zero_count", 64'(busy_count), 64'h0);
    // fill registers 0..30 with the pattern
    for (int i = 0; i < 31; i++) begin
      reg_write = 1'b1; write_register = 5'(i); write_data = 64'(i) * PAT;
      tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      read_register = {5'(i), 5'(i - 1)};
      #1;
      chk($sformatf("fill_p0_r%0d", i - 1), rd_data[63:0], 64'(i - 1) * PAT);
      chk($sformatf("fill_p1_r%0d", i), rd_data[127:64], (i == 31) ? 64'h0 : 64'(i) * PAT);
    end
    // same-cycle forwarding versus the non-bypass build
    reg_write = 1'b1; write_register = 5'd5; write_data = 64'hDEAD;
    read_register = {5'd0, 5'd5};
    #1;
    chk("bypass_same_cycle", rd_data[63:0], 64'hDEAD);
    chk("nobypass_old_value", nb_data[63:0], 64'd5 * PAT);
    tick();
    idle();
    #1;
    chk("nobypass_next_cycle", nb_data[63:0], 64'hDEAD);
    // reserve then complete register 7
    reserve = 1'b1; reserve_register = 5'd7;
    tick();
    idle();
    read_register = {5'd7, 5'd7};
    #1;
    chk("rsv7_busy", 64'(rd_busy), 64'h3);
    chk("rsv7_count", 64'(busy_count), 64'h1);
    reg_write = 1'b1; write_register = 5'd7; write_data = 64'h1234;
    #1;
    chk("wr7_busy_bypass", 64'(rd_busy), 64'h0);
    chk("wr7_busy_nobypass", 64'(nb_busy), 64'h3);
    chk("wr7_count_hold", 64'(busy_count), 64'h1);
    tick();
    idle();
    #1;
    chk("wr7_count_after", 64'(busy_count), 64'h0);
    chk("wr7_data", rd_data[63:0], 64'h1234);
    // reserve wins over a write to the same register
    reserve = 1'b1; reserve_register = 5'd9;
    reg_write = 1'b1; write_register = 5'd9; write_data = 64'h5555;
    read_register = {5'd9, 5'd9};
    tick();
    idle();
    #1;
    chk("r9_busy", 64'(rd_busy), 64'h3);
    chk("r9_count", 64'(busy_count), 64'h1);
    chk("r9_data", rd_data[127:64], 64'h5555);
    reserve = 1'b1; reserve_register = 5'd9;
    tick();
    idle();
    #1;
    chk("r9_rereserve_count", 64'(busy_count), 64'h1);
    chk("r9_rereserve_busy", 64'(rd_busy), 64'h3);
    // several pending producers, then asynchronous reset mid-cycle
    for (int r = 1; r < 4; r++) begin
      reserve = 1'b1; reserve_register = 5'(r);
      tick();
    end
    idle();
    #1;
    chk("multi_count", 64'(busy_count), 64'h4);
    reg_write = 1'b1; write_register = 5'd1; write_data = 64'h11;
    tick();
    idle();
    #1;
    chk("multi_count_dec", 64'(busy_count), 64'h3);
    reg_write = 1'b1; write_register = 5'd2; write_data = 64'h22;
    reserve = 1'b1; reserve_register = 5'd4;
    read_register = {5'd3, 5'd2};
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_data", 64'(rd_data[63:0] | rd_data[127:64]), 64'h0);
    chk("async_nb_data", 64'(nb_data[63:0] | nb_data[127:64]), 64'h0);
    chk("async_busy", 64'(rd_busy), 64'h0);
    chk("async_count", 64'(busy_count), 64'h0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    tick();
    read_register = {5'd9, 5'd2};
    #1;
    chk("post_reset_count", 64'(busy_count), 64'h0);
    chk("post_reset_r2", rd_data[63:0], 64'h0);
    chk("post_reset_r9", rd_data[127:64], 64'h0);
    chk("post_reset_busy", 64'(rd_busy), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with same-cycle write bypass, optional hardwired-zero register, and an integrated busy scoreboard for pending long-latency writes. Next generation of the CPU's 32×64 two-read-port file: it sits in decode, feeds operand reads to execute, and takes the single writeback port. Register contents are flops cleared by asynchronous reset. The scoreboard lets issue logic detect read-after-write hazards on loads and multi-cycle ops.

## Interface
- DATA_WIDTH, 64, bits per register
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_EN, 1, when 1 register ZERO_IDX always reads 0, ignores writes and reservations
- ZERO_IDX, 2**ADDR_WIDTH-1, index of hardwired-zero register
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- RegWrite  in  1  write enable
- WriteRegister  in  ADDR_WIDTH  write index
- WriteData  in  DATA_WIDTH  write data
- Reserve  in  1  mark ReserveRegister busy (pending producer issued)
- ReserveRegister  in  ADDR_WIDTH  index to reserve
- ReadRegister  in  NUM_READ×ADDR_WIDTH  packed read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- ReadData  out  NUM_READ×DATA_WIDTH  packed read data, same packing
- ReadBusy  out  NUM_READ  per-port busy flag for the addressed register
- BusyCount  out  ADDR_WIDTH+1  number of currently busy registers

## Operation
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits; write on rising clk when RegWrite=1 and not (ZERO_EN and WriteRegister==ZERO_IDX).
- Reads combinational from storage. Port p: if ZERO_EN and index==ZERO_IDX -> 0; else if BYPASS and effective write and WriteRegister==index -> WriteData; else stored value.
- Scoreboard: one busy bit per register. Effective write clears bit WriteRegister; Reserve sets bit ReserveRegister. Reservation of ZERO_IDX (ZERO_EN=1) ignored; bit stays 0.
- Same register reserved and written in one cycle: reserve wins, bit ends 1 (new producer supersedes the completing one).
- Write to a non-busy register: data written, bit stays 0, no error.
- ReadBusy[p] = busy bit of addressed register, forced 0 when BYPASS and an effective write to that index occurs this cycle (and no Reserve of it).
- BusyCount: registered counter updated incrementally: +1 if a reserve sets a previously clear bit, −1 if a write clears a previously set bit (not overridden), both or neither -> unchanged. Never exceeds depth, never below 0.

## Timing
- Reset (reset_n=0, asynchronous): all registers 0, all busy bits 0, BusyCount 0; ReadData therefore 0, ReadBusy 0 immediately. Reset deassertion takes effect at next clk edge.
- Reset mid-operation discards pending writes and reservations; no partial state survives.
- Write latency: value visible on ReadData in the same cycle with BYPASS=1, from the cycle after the edge with BYPASS=0.
- Reserve latency: ReadBusy asserts the cycle after the Reserve edge; BusyCount updates on the same edge.
- No handshake, no stall: every port accepted every cycle.

## Structure
- regfile_pkg: default parameter constants (DATA_WIDTH, ADDR_WIDTH, ZERO_IDX), clog2-based depth helper.
- Sub-module regfile_scoreboard: busy-bit vector, reserve/clear priority, BusyCount counter, per-port busy lookup with bypass clear. Storage, write decode and read muxing stay in regfile_mp.

## Test plan
- Reset, then write 64'hA0 to reg 31 (ZERO_EN=1) and Reserve 31 -> reads of 31 return 0, ReadBusy 0, BusyCount 0.
- Write i*64'h0000010204080001 to regs 0..30, then read all on both ports with offset indices i-1, i -> each port returns the pattern, reg 31 returns 0.
- BYPASS=1: write 64'hDEAD to reg 5 while port 0 reads 5 -> ReadData port 0 = 64'hDEAD same cycle; BYPASS=0 build -> old value this cycle, 64'hDEAD next.
- Reserve 7 -> next cycle ReadBusy=1, BusyCount=1; write 7 with 64'h1234 -> that cycle ReadBusy=0 (BYPASS), next cycle BusyCount=0.
- Reserve and write reg 9 in the same cycle -> bit 9 stays busy, BusyCount=1, data reads 64'h write value; reserve 9 again -> BusyCount stays 1.
- Reserve regs 1..3, write regs 1..3, assert reset_n=0 mid-sequence between clk edges -> all outputs 0 immediately, BusyCount 0 after release.
